lsu_sequencer: RTL and testbench

Load/store sequencer between the datapath's memory stage and the byte-wide data memory array. It accepts one load/store request at a time and checks alignment and range. It then performs the access as a sequence of single-byte memory cycles in big-endian order, and returns sign- or zero-extended load data or a store completion. It replaces direct multi-byte combinational access with a clocked, handshaked stage that owns all byte-lane and extension logic.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_load_extend.sv | 20 ++
 rtl/lsu_sequencer.sv | 156 +++++++++++++++
 tb/tb_lsu_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: op field layout, size codes,
// FSM states and the access-size helper.
package lsu_pkg;

  localparam int OP_STORE = 3;
  localparam int OP_UNS   = 2;
  localparam int OP_SZ_HI = 1;
  localparam int OP_SZ_LO = 0;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Reserved size returns 0; such requests never reach ACCESS.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_B:    nbytes = 3'd1;
      SZ_H:    nbytes = 3'd2;
      SZ_W:    nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of a right-justified loaded value to 32 bits.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_raw;
    case (i_size)
      SZ_B:    o_data = {{24{~i_uns & i_raw[7]}}, i_raw[7:0]};
      SZ_H:    o_data = {{16{~i_uns & i_raw[15]}}, i_raw[15:0]};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: validates one request, then walks it byte by byte
// through the memory array in big-endian order and returns a single response.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int MA_W      = $clog2(MEM_BYTES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic [MA_W-1:0] mem_addr,
  output logic            mem_we,
  output logic [7:0]      mem_wdata,
  input  logic [7:0]      mem_rdata
);

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_op;
  logic [1:0]      r_idx;
  logic [MA_W-1:0] r_base;
  logic [31:0]     r_wdata;
  logic [23:0]     r_sreg;
  logic [31:0]     r_rsp_rdata;
  logic            r_rsp_err;

  logic [1:0]      w_req_size;
  logic [2:0]      w_req_n;
  logic            w_misalign;
  logic            w_range;
  logic            w_req_err;
  logic            w_accept;
  logic [1:0]      w_size;
  logic            w_store;
  logic [2:0]      w_n;
  logic            w_last;
  logic [31:0]     w_sreg_next;
  logic [31:0]     w_ext;
  logic [1:0]      w_lane;
  logic [7:0]      w_store_byte;

  assign w_req_size = req_op[OP_SZ_HI:OP_SZ_LO];
  assign w_req_n    = nbytes(w_req_size);
  assign w_misalign = ((w_req_size == SZ_H) && req_addr[0]) ||
                      ((w_req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  assign w_range    = ({1'b0, req_addr} + {30'd0, w_req_n}) > 33'(MEM_BYTES);
  assign w_req_err  = (w_req_size == SZ_R) || w_misalign || w_range;
  assign w_accept   = (r_state == IDLE) && req_valid;

  assign w_size      = r_op[OP_SZ_HI:OP_SZ_LO];
  assign w_store     = r_op[OP_STORE];
  assign w_n         = nbytes(w_size);
  assign w_last      = (r_idx == 2'(w_n - 3'd1));
  assign w_sreg_next = {r_sreg, mem_rdata};

  lsu_load_extend u_ext (
    .i_size (w_size),
    .i_uns  (r_op[OP_UNS]),
    .i_raw  (w_sreg_next),
    .o_data (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = w_req_err ? RESP : ACCESS;
      ACCESS:  if (w_last) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Byte lane of the store word for the current idx (lane 0 = bits 31:24).
  always_comb begin
    case (w_size)
      SZ_W:    w_lane = r_idx;
      SZ_H:    w_lane = {1'b1, r_idx[0]};
      default: w_lane = 2'd3;
    endcase
    case (w_lane)
      2'd0:    w_store_byte = r_wdata[31:24];
      2'd1:    w_store_byte = r_wdata[23:16];
      2'd2:    w_store_byte = r_wdata[15:8];
      default: w_store_byte = r_wdata[7:0];
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'd0;
    case (r_state)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        mem_addr  = r_base + MA_W'(r_idx);
        mem_we    = w_store;
        mem_wdata = w_store ? w_store_byte : 8'd0;
      end
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= 4'd0;
      r_idx       <= 2'd0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_op  <= req_op;
        r_idx <= 2'd0;
        if (w_req_err) begin
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= 32'd0;
        end
      end else if (r_state == ACCESS) begin
        r_idx <= r_idx + 2'd1;
        if (w_last) begin
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= w_store ? 32'd0 : w_ext;
        end
      end
    end
  end

  // Datapath holding registers carry no reset; they are only observed under valid state.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_base  <= req_addr[MA_W-1:0];
      r_wdata <= req_wdata;
    end
    if (r_state == ACCESS) r_sreg <= w_sreg_next[23:0];
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer with a byte-array memory and a
// reference model that computes each response from a shadow memory image.
module tb_lsu_sequencer;
  import lsu_pkg::*;

  localparam int MEM_BYTES = 256;
  localparam int MA_W      = 8;

  bit              clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic            rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [MA_W-1:0] mem_addr;
  logic            mem_we;
  logic [7:0]      mem_wdata;
  logic [7:0]      mem_rdata;

  always #5 clk = ~clk;

  lsu_sequencer #(.MEM_BYTES(MEM_BYTES), .MA_W(MA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [7:0] mem [MEM_BYTES];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign mem_rdata = mem[mem_addr];

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ref_mem [MEM_BYTES];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata);
    exp_t    e;
    int      n;
    int      sz;
    longint  v;
    sz = int'(op[1:0]);
    n  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    e.acc = 0;
    e.err = (sz == 3) || ((addr % n) != 0) ||
            (({32'd0, addr} + 64'(n)) > 64'(MEM_BYTES));
    e.rdata = 32'd0;
    if (e.err) begin
      e.lat = 1;
      e.nwe = 0;
    end else begin
      e.lat = n + 1;
      if (op[3]) begin
        e.nwe = n;
        for (int i = 0; i < n; i++)
          ref_mem[8'(addr + 32'(i))] = 8'((wdata >> (8 * (n - 1 - i))) & 32'hFF);
      end else begin
        e.nwe = 0;
        v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[8'(addr + 32'(i))]);
        if (!op[2] && (((v >> (8 * n - 1)) & 1) == 1)) v = v - (64'd1 << (8 * n));
        e.rdata = v[31:0];
      end
    end
    return e;
  endfunction

  task automatic monitor();
    int   nwe;
    exp_t e;
    nwe = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) nwe = 0;
      else begin
        if (mem_we) nwe++;
        if (rsp_valid) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h, expected no response", rsp_rdata);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("mem_we_cycles", 32'(nwe), 32'(e.nwe));
          end
          nwe = 0;
        end
      end
    end
  endtask

  // Presents a request and returns at the negedge just before the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit track, output int acc);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    acc = cyc;
    if (!req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, expected 1", guard);
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      e = model(op, addr, wdata);
      e.acc = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic xfer(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    int acc;
    issue(op, addr, wdata, 1'b1, acc);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() > 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int   acc;
    int   prev_acc;
    int   prev_n;
    int   bad;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [7:0]  b;

    fork
      monitor();
      begin
        repeat (40000) @(posedge clk);
        $display("FAIL watchdog: got no completion in 40000 cycles, expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    pre_we    = 1'b0;
    pre_addr  = 8'd0;
    pre_data  = 8'd0;

    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);

    for (int i = 0; i < MEM_BYTES; i++) begin
      case (i)
        16'h10:  b = 8'h80;
        16'h11:  b = 8'h12;
        16'h12:  b = 8'h34;
        16'h13:  b = 8'h56;
        default: b = 8'($urandom);
      endcase
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = 8'(i);
      pre_data = b;
      ref_mem[i] = b;
    end
    @(negedge clk);
    pre_we = 1'b0;
    rst_n  = 1'b1;

    // Directed loads of the preset word.
    xfer(4'b0010, 32'h10, 32'h0);
    xfer(4'b0000, 32'h10, 32'h0);
    xfer(4'b0100, 32'h10, 32'h0);
    xfer(4'b0001, 32'h12, 32'h0);
    xfer(4'b0101, 32'h10, 32'h0);
    // Stores then read-back.
    xfer(4'b1010, 32'h20, 32'hDEADBEEF);
    xfer(4'b1000, 32'h21, 32'h00000077);
    xfer(4'b0010, 32'h20, 32'h0);
    // Error cases and the last legal word.
    xfer(4'b0001, 32'h11, 32'h0);
    xfer(4'b1010, 32'h22, 32'h12345678);
    xfer(4'b0010, 32'h100, 32'h0);
    xfer(4'b0011, 32'h40, 32'h0);
    xfer(4'b0010, 32'hFC, 32'h0);
    xfer(4'b0010, 32'hFFFFFFFC, 32'h0);
    drain();

    // req_valid held high across alternating LW/SB.
    prev_acc = 0;
    prev_n   = 0;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        issue(4'b0010, 32'h20, 32'h0, 1'b1, acc);
        if (k > 0) chk("spacing_after_sb", 32'(acc - prev_acc), 32'(prev_n + 2));
        prev_n = 4;
      end else begin
        issue(4'b1000, 32'h20 + 32'($urandom_range(0, 3)), $urandom, 1'b1, acc);
        chk("spacing_after_lw", 32'(acc - prev_acc), 32'(prev_n + 2));
        prev_n = 1;
      end
      prev_acc = acc;
    end
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    // Reset during the second ACCESS cycle of a word store.
    issue(4'b1010, 32'h30, 32'hAABBCCDD, 1'b0, acc);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    ref_mem[8'h30] = 8'hAA;
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_mem_30", 32'(mem[8'h30]), 32'(ref_mem[8'h30]));
    chk("abort_mem_31", 32'(mem[8'h31]), 32'(ref_mem[8'h31]));
    xfer(4'b0010, 32'h30, 32'h0);

    // Randomized mix of legal and illegal requests.
    for (int k = 0; k < 80; k++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       addr = 32'($urandom_range(248, 271));
        1:       addr = $urandom;
        default: addr = 32'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 3) != 0 && op[1:0] == 2'b10) addr = addr & ~32'h3;
      if ($urandom_range(0, 3) != 0 && op[1:0] == 2'b01) addr = addr & ~32'h1;
      xfer(op, addr, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image_bad_bytes", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
